// File: rtl/fdct_butterfly1.sv
// Forward-DCT first butterfly stage: collects one 8-sample row serially, then
// registers the even/odd stage-1 sums and differences for the multiply stage.
module fdct_butterfly1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] e0,
  output logic [WIDTH-1:0] e1,
  output logic [WIDTH-1:0] e2,
  output logic [WIDTH-1:0] e3,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3
);

  logic [2:0]       cnt;
  logic [WIDTH-1:0] x_buf [8];
  logic             row_full;
  logic             accept;
  logic             transfer;

  logic [WIDTH-1:0] u0, u1, u2, u3;
  logic [WIDTH-1:0] e0_n, e1_n, e2_n, e3_n;
  logic [WIDTH-1:0] o0_n, o1_n, o2_n, o3_n;

  // A full row blocks input until the output register can take it, so the
  // handshake signals depend on state only.
  assign in_ready = !row_full;
  assign accept   = in_valid && !row_full && !flush;
  assign transfer = row_full && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      row_full <= 1'b0;
    end else begin
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 3'd1;
      end

      if (transfer) begin
        row_full <= 1'b0;
      end else if (accept && (cnt == 3'd7)) begin
        row_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        x_buf[i] <= '0;
      end
    end else if (accept) begin
      x_buf[cnt] <= in_data;
    end
  end

  // Plain modulo-2^WIDTH arithmetic: no widening, no saturation.
  always_comb begin
    u0   = x_buf[0] + x_buf[7];
    u1   = x_buf[1] + x_buf[6];
    u2   = x_buf[2] + x_buf[5];
    u3   = x_buf[3] + x_buf[4];
    e0_n = u0 + u3;
    e1_n = u1 + u2;
    e2_n = u1 - u2;
    e3_n = u0 - u3;
    o0_n = x_buf[3] - x_buf[4];
    o1_n = x_buf[2] - x_buf[5];
    o2_n = x_buf[1] - x_buf[6];
    o3_n = x_buf[0] - x_buf[7];
  end

  // A transfer coinciding with a drain replaces the result and keeps out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      e0        <= '0;
      e1        <= '0;
      e2        <= '0;
      e3        <= '0;
      o0        <= '0;
      o1        <= '0;
      o2        <= '0;
      o3        <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      e0        <= e0_n;
      e1        <= e1_n;
      e2        <= e2_n;
      e3        <= e3_n;
      o0        <= o0_n;
      o1        <= o1_n;
      o2        <= o2_n;
      o3        <= o3_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fdct_butterfly1.sv
// Bench for fdct_butterfly1: table-driven rows, backpressure/flush/reset
// sequences, then randomized rows scored against a formula-level model.
module tb_fdct_butterfly1;
  localparam int WIDTH = 32;
  localparam int RW    = 8 * WIDTH;
  localparam int NV    = 5;
  localparam int NROWS = 1000;

  typedef logic [7:0][WIDTH-1:0] row_t;
  typedef struct packed {
    row_t x;
    row_t exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] e0, e1, e2, e3, o0, o1, o2, o3;

  int checks = 0;
  int errors = 0;

  bit               mon_on   = 1'b0;
  bit               rand_on  = 1'b0;
  bit               held_prev = 1'b0;
  row_t             held_val;
  row_t             mon_xs;
  logic [WIDTH-1:0] samp_q [$];
  row_t             exp_q [$];
  int               rows_out = 0;

  vec_t tbl [NV];
  int tx [NV][8] = '{
    '{1, 2, 3, 4, 5, 6, 7, 8},
    '{32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 1},
    '{10, 20, 30, 40, 50, 60, 70, 80},
    '{-1, 2, -3, 4, -5, 6, -7, 8},
    '{100, 0, 0, 0, 0, 0, 0, 0}
  };
  // Order: e0, e1, e2, e3, o0, o1, o2, o3
  int te [NV][8] = '{
    '{18, 18, 0, 0, -1, -3, -5, -7},
    '{32'h8000_0000, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h7FFF_FFFE},
    '{180, 180, 0, 0, -10, -30, -50, -70},
    '{6, -2, -8, 8, 9, -9, 9, -9},
    '{100, 0, 0, 100, 0, 0, 0, 100}
  };

  fdct_butterfly1 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .e0(e0), .e1(e1), .e2(e2), .e3(e3),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3)
  );

  always #5 clk = ~clk;

  // Even part uses mirrored-pair sums, odd part mirrored-pair differences.
  function automatic row_t ref_model(input row_t x);
    row_t r;
    r[0] = (x[0] + x[7]) + (x[3] + x[4]);
    r[1] = (x[1] + x[6]) + (x[2] + x[5]);
    r[2] = (x[1] + x[6]) - (x[2] + x[5]);
    r[3] = (x[0] + x[7]) - (x[3] + x[4]);
    for (int k = 0; k < 4; k++) r[4+k] = x[3-k] - x[4+k];
    return r;
  endfunction

  function automatic row_t dut_res();
    row_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    r[4] = o0; r[5] = o1; r[6] = o2; r[7] = o3;
    return r;
  endfunction

  task automatic checkOutput(input string name, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d);
    bit taken;
    int guard;
    taken    = 1'b0;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!taken && guard < 200) begin
      taken = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic send_row(input row_t xs);
    for (int k = 0; k < 8; k++) applyStimulus(xs[k]);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Scoreboard: samples accepted on the input side form rows that must
  // come out in order on the output handshake; held results must not move.
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (held_prev) begin
        checkOutput("hold_valid", RW'(out_valid), RW'(1));
        checkOutput("hold_data", dut_res(), held_val);
      end
      held_prev = out_valid && !out_ready;
      held_val  = dut_res();
      if (in_valid && in_ready && !flush) begin
        samp_q.push_back(in_data);
        if (samp_q.size() == 8) begin
          for (int k = 0; k < 8; k++) mon_xs[k] = samp_q[k];
          exp_q.push_back(ref_model(mon_xs));
          samp_q.delete();
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_row: got row %0d with none pending", rows_out);
        end else begin
          checkOutput($sformatf("row_%0d", rows_out), dut_res(), exp_q.pop_front());
        end
        rows_out++;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int guard;
    logic [WIDTH-1:0] d;
    row_t row_a, row_b;

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < 8; k++) begin
        tbl[i].x[k]   = tx[i][k];
        tbl[i].exp[k] = te[i][k];
      end
    end

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    checkOutput("reset_out_valid", RW'(out_valid), RW'(0));
    checkOutput("reset_outputs", dut_res(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("reset_in_ready", RW'(in_ready), RW'(1));

    // Table rows with a free output: latency, one-cycle in_ready gap, pulse.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send_row(tbl[i].x);
      checkOutput($sformatf("tbl%0d_in_ready_low", i), RW'(in_ready), RW'(0));
      wait_valid(10, cyc);
      checkOutput($sformatf("tbl%0d_latency", i), RW'(cyc), RW'(1));
      checkOutput($sformatf("tbl%0d_data", i), dut_res(), tbl[i].exp);
      checkOutput($sformatf("tbl%0d_in_ready_back", i), RW'(in_ready), RW'(1));
      @(posedge clk); #1;
      checkOutput($sformatf("tbl%0d_pulse", i), RW'(out_valid), RW'(0));
    end

    // Backpressure: A held while B is collected, then both drain in order.
    row_a = tbl[0].x;
    row_b = tbl[2].x;
    out_ready = 1'b0;
    send_row(row_a);
    send_row(row_b);
    checkOutput("bp_in_ready_low", RW'(in_ready), RW'(0));
    for (int c = 0; c < 20; c++) begin
      checkOutput("bp_hold_valid", RW'(out_valid), RW'(1));
      checkOutput("bp_hold_a", dut_res(), tbl[0].exp);
      checkOutput("bp_in_ready_held", RW'(in_ready), RW'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_b_valid", RW'(out_valid), RW'(1));
    checkOutput("bp_b_data", dut_res(), tbl[2].exp);
    checkOutput("bp_in_ready_free", RW'(in_ready), RW'(1));
    @(posedge clk); #1;
    checkOutput("bp_drained", RW'(out_valid), RW'(0));

    // Flush after 5 samples with a coincident sample, then a flush at row start.
    for (int k = 0; k < 5; k++) applyStimulus(WIDTH'(99 + k));
    flush = 1'b1; in_valid = 1'b1; in_data = 77;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 55;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    send_row(tbl[0].x);
    wait_valid(10, cyc);
    checkOutput("flush_latency", RW'(cyc), RW'(1));
    checkOutput("flush_data", dut_res(), tbl[0].exp);
    @(posedge clk); #1;
    checkOutput("flush_pulse", RW'(out_valid), RW'(0));

    // Asynchronous reset mid-row.
    for (int k = 0; k < 4; k++) applyStimulus(WIDTH'(500 + k));
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", RW'(out_valid), RW'(0));
    checkOutput("rst_mid_outputs", dut_res(), '0);
    checkOutput("rst_mid_in_ready", RW'(in_ready), RW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_row(tbl[3].x);
    wait_valid(10, cyc);
    checkOutput("rst_mid_latency", RW'(cyc), RW'(1));
    checkOutput("rst_mid_data", dut_res(), tbl[3].exp);
    @(posedge clk); #1;

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    send_row(tbl[0].x);
    wait_valid(10, cyc);
    checkOutput("rst_held_valid_pre", RW'(out_valid), RW'(1));
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_held_valid", RW'(out_valid), RW'(0));
    checkOutput("rst_held_outputs", dut_res(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_row(tbl[4].x);
    wait_valid(10, cyc);
    checkOutput("rst_held_latency", RW'(cyc), RW'(1));
    checkOutput("rst_held_data", dut_res(), tbl[4].exp);
    @(posedge clk); #1;
    checkOutput("rst_held_pulse", RW'(out_valid), RW'(0));

    // Randomized rows with input gaps and random downstream stalls.
    mon_on  = 1'b1;
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int r = 0; r < NROWS; r++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
          end
        end
        d = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom());
        applyStimulus(d);
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (rows_out < NROWS && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    rand_on = 1'b0;
    @(posedge clk); #1;
    checkOutput("rand_rows_out", RW'(rows_out), RW'(NROWS));
    checkOutput("rand_pending", RW'(exp_q.size()), RW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
